dsp_sequencer: RTL and testbench
================================

DSP_SEQUENCER -- requirements
Module: dsp_sequencer

Interface
REQ-001 Parameters: DW, 20, stream word width; DEF_FTW, 32'h0, power-on DDS tuning word; DEF_DECIM, 13'd48, power-on decimation; MIN_DECIM, 13'd16, smallest accepted decimation; RST_CYCLES, 4, dsp reset pulse length; SETTLE_FRAMES, 2, output frames discarded after retune.
REQ-002 Ports: clk, in, 1, ADC clock, the only clock; reset, in, 1, synchronous active-high reset.
REQ-003 cfg_ftw, in, 32, requested DDS tuning word; cfg_decim, in, 13, requested decimation; cfg_wr, in, 1, one-cycle write strobe.
REQ-004 cfg_busy, out, 1, high unless state is RUN with no pending request; err_decim, out, 1, sticky rejected-write flag; err_clr, in, 1, clears err_decim.
REQ-005 dds_ftw, out, 32, and decimation, out, 13, drive the dsp datapath; dsp_reset, out, 1, datapath reset.
REQ-006 stream_in, in, DW, and strobe_in, in, 1, carry the dsp result_iq/strobe_cc; stream_out, out, DW, and strobe_out, out, 1, carry the gated stream; frame_cnt, out, 16, count of forwarded frames.

Function
REQ-007 A frame is a run of consecutive strobe_in-high cycles; frame end is the cycle where strobe_in is 0 and the registered prior strobe_in is 1.
REQ-008 States: HOLD, SETTLE, RUN, PEND; all transitions are on clk.
REQ-009 HOLD: dsp_reset=1 for exactly RST_CYCLES cycles, then SETTLE.
REQ-010 SETTLE: dsp_reset=0; count frame ends; after SETTLE_FRAMES frame ends go to RUN (PEND instead if the shadow is valid).
REQ-011 RUN: forward stream; on accepted cfg_wr go to PEND.
REQ-012 PEND: keep forwarding; at the next frame end load shadow into dds_ftw/decimation, clear the shadow-valid bit and go to HOLD in the same cycle.
REQ-013 cfg_wr with cfg_decim >= MIN_DECIM is accepted into a shadow register in every state; last write wins; the shadow is applied only via PEND.
REQ-014 cfg_wr with cfg_decim < MIN_DECIM is ignored and sets err_decim; if err_clr and a rejected write coincide, err_decim stays set.
REQ-015 stream_out/strobe_out are registered with 1-cycle latency: strobe_out = strobe_in AND (state RUN or PEND); stream_out holds its last value when strobe_out=0.
REQ-016 Gating changes only at frame ends, so only complete frames are forwarded.
REQ-017 frame_cnt increments on each forwarded frame end and wraps from 16'hFFFF to 0.
REQ-018 dds_ftw and decimation change only on the PEND->HOLD transition and are stable at all other times.

Reset
REQ-019 On reset: state HOLD with cycle counter 0; dds_ftw=DEF_FTW; decimation=DEF_DECIM; dsp_reset=1; strobe_out=0; stream_out=0; frame_cnt=0; err_decim=0; shadow invalid; cfg_busy=1.
REQ-020 Reset asserted in any state aborts the sequence and discards the shadow; a cfg_wr coincident with reset is dropped.

Configuration
REQ-021 Macro DSP_SEQ_TIMEOUT_EN: when defined, a 14-bit watchdog runs in SETTLE and PEND and restarts on every frame end.
REQ-022 With DSP_SEQ_TIMEOUT_EN, a watchdog count of 16383 forces the pending frame-end action: SETTLE goes to RUN/PEND and PEND loads the shadow and goes to HOLD.
REQ-023 Without DSP_SEQ_TIMEOUT_EN, no watchdog logic exists and SETTLE/PEND wait indefinitely for frame ends.

Verification
REQ-024 Reset release with 8-cycle frames every 48 cycles -> dsp_reset high 4 cycles; first 2 frames dropped; 3rd frame appears on strobe_out 1 cycle late; frame_cnt=1 after it.
REQ-025 In RUN, cfg_wr ftw=32'h12345678, decim=64 mid-frame -> that frame is forwarded whole; at its end dds_ftw=32'h12345678 and decimation=64; dsp_reset 4 cycles; 2 frames dropped.
REQ-026 cfg_wr decim=8 -> no state change, err_decim=1; err_clr -> err_decim=0; simultaneous err_clr and decim=8 write -> err_decim=1.
REQ-027 Two cfg_wr (ftw A then B) during SETTLE -> only B is applied; exactly one extra HOLD sequence follows.
REQ-028 frame_cnt preloaded near 16'hFFFF via forced frames -> wraps to 0; reset asserted mid-PEND -> returns to DEF values and no apply occurs.
REQ-029 With DSP_SEQ_TIMEOUT_EN, strobe_in held 0 in PEND -> apply occurs 16384 cycles after PEND entry; without the macro, the block stays in PEND.

Source files
------------

// File: rtl/dsp_sequencer.sv
// Retune sequencer for the DDS/decimator datapath: shadows config writes, applies them at frame
// boundaries, pulses the datapath reset and forwards only complete frames. Optional macro: DSP_SEQ_TIMEOUT_EN.
module dsp_sequencer #(
    parameter int          DW            = 20,
    parameter logic [31:0] DEF_FTW       = 32'h0,
    parameter logic [12:0] DEF_DECIM     = 13'd48,
    parameter logic [12:0] MIN_DECIM     = 13'd16,
    parameter int          RST_CYCLES    = 4,
    parameter int          SETTLE_FRAMES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   cfg_ftw,
    input  logic [12:0]   cfg_decim,
    input  logic          cfg_wr,
    output logic          cfg_busy,
    output logic          err_decim,
    input  logic          err_clr,
    output logic [31:0]   dds_ftw,
    output logic [12:0]   decimation,
    output logic          dsp_reset,
    input  logic [DW-1:0] stream_in,
    input  logic          strobe_in,
    output logic [DW-1:0] stream_out,
    output logic          strobe_out,
    output logic [15:0]   frame_cnt
);

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {HOLD, SETTLE, RUN, PEND} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_strb_prev;
    logic               w_fend;
    logic               w_accept;
    logic               w_reject;
    logic               w_apply;
    logic               w_fwd;
    logic               w_to;
    logic [31:0]        r_shadow_ftw;
    logic [12:0]        r_shadow_decim;
    logic               r_shadow_vld;
    logic [31:0]        r_ftw;
    logic [12:0]        r_decim;
    logic               vld_p1;
    logic [DW-1:0]      r_stream_p1;
    logic [15:0]        r_frame_cnt;
    logic               r_err;

    assign w_fend   = !strobe_in && r_strb_prev;
    assign w_accept = cfg_wr && (cfg_decim >= MIN_DECIM);
    assign w_reject = cfg_wr && (cfg_decim < MIN_DECIM);
    assign w_fwd    = (r_state == RUN) || (r_state == PEND);

`ifdef DSP_SEQ_TIMEOUT_EN
    logic [13:0] r_wdog;

    assign w_to = (r_wdog == 14'h3FFF);

    // Watchdog stands in for a missing frame end; cleared outside the waiting states.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog <= '0;
        end else if ((r_state == SETTLE || r_state == PEND) && !w_fend && !w_to) begin
            r_wdog <= r_wdog + 14'd1;
        end else begin
            r_wdog <= '0;
        end
    end
`else
    assign w_to = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_apply     = 1'b0;
        case (r_state)
            HOLD: begin
                if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (w_to || (w_fend && r_cnt == CNT_W'(SETTLE_FRAMES - 1))) begin
                    w_state_nxt = (r_shadow_vld || w_accept) ? PEND : RUN;
                    w_cnt_nxt   = '0;
                end else if (w_fend) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (w_accept || r_shadow_vld) begin
                    w_state_nxt = PEND;
                end
            end
            PEND: begin
                if (w_fend || w_to) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                    w_apply     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = HOLD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= HOLD;
            r_cnt       <= '0;
            r_strb_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_strb_prev <= strobe_in;
        end
    end

    // A write landing on the apply cycle is the newest one, so it is applied directly.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shadow_ftw   <= cfg_ftw;
            r_shadow_decim <= cfg_decim;
        end
        if (reset) begin
            r_shadow_vld <= 1'b0;
            r_ftw        <= DEF_FTW;
            r_decim      <= DEF_DECIM;
        end else if (w_apply) begin
            r_shadow_vld <= 1'b0;
            r_ftw        <= w_accept ? cfg_ftw   : r_shadow_ftw;
            r_decim      <= w_accept ? cfg_decim : r_shadow_decim;
        end else if (w_accept) begin
            r_shadow_vld <= 1'b1;
        end
    end

    // Stage p1: gated output stream
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            r_stream_p1 <= '0;
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            vld_p1 <= strobe_in && w_fwd;
            if (strobe_in && w_fwd) begin
                r_stream_p1 <= stream_in;
            end
            if (w_fend && vld_p1) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_reject) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign cfg_busy   = !((r_state == RUN) && !r_shadow_vld);
    assign dsp_reset  = (r_state == HOLD);
    assign err_decim  = r_err;
    assign dds_ftw    = r_ftw;
    assign decimation = r_decim;
    assign stream_out = r_stream_p1;
    assign strobe_out = vld_p1;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_dsp_sequencer.sv
// Directed bench for dsp_sequencer: reset, settle/run gating, retune, error flag, wrap and watchdog.
module tb_dsp_sequencer;

    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   cfg_ftw;
    logic [12:0]   cfg_decim;
    logic          cfg_wr;
    logic          cfg_busy;
    logic          err_decim;
    logic          err_clr;
    logic [31:0]   dds_ftw;
    logic [12:0]   decimation;
    logic          dsp_reset;
    logic [DW-1:0] stream_in;
    logic          strobe_in;
    logic [DW-1:0] stream_out;
    logic          strobe_out;
    logic [15:0]   frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rst   = 0;
    int n_sout  = 0;
    int s_rst;
    int s_sout;

    dsp_sequencer #(.DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cfg_ftw(cfg_ftw), .cfg_decim(cfg_decim), .cfg_wr(cfg_wr),
        .cfg_busy(cfg_busy), .err_decim(err_decim), .err_clr(err_clr),
        .dds_ftw(dds_ftw), .decimation(decimation), .dsp_reset(dsp_reset),
        .stream_in(stream_in), .strobe_in(strobe_in),
        .stream_out(stream_out), .strobe_out(strobe_out), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dsp_reset)  n_rst  <= n_rst + 1;
        if (strobe_out) n_sout <= n_sout + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        strobe_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic frame_part(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            strobe_in = 1'b1;
            stream_in = base + DW'(i);
            tick();
        end
    endtask

    task automatic frame(input int n, input logic [DW-1:0] base);
        frame_part(n, base);
        strobe_in = 1'b0;
        tick();
    endtask

    task automatic write_cfg(input logic [31:0] ftw, input logic [12:0] dec);
        cfg_wr = 1'b1; cfg_ftw = ftw; cfg_decim = dec;
        tick();
        cfg_wr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_ftw = '0; cfg_decim = '0; cfg_wr = 1'b0; err_clr = 1'b0;
        stream_in = '0; strobe_in = 1'b0;
        repeat (3) tick();
        chk("rst_ftw",    dds_ftw, 32'h0);
        chk("rst_decim",  32'(decimation), 32'd48);
        chk("rst_dsprst", 32'(dsp_reset), 32'd1);
        chk("rst_sout",   32'(strobe_out), 32'd0);
        chk("rst_stream", 32'(stream_out), 32'd0);
        chk("rst_fcnt",   32'(frame_cnt), 32'd0);
        chk("rst_err",    32'(err_decim), 32'd0);
        chk("rst_busy",   32'(cfg_busy), 32'd1);

        // Startup: 4-cycle datapath reset, two frames dropped, third forwarded
        reset = 1'b0;
        s_rst = n_rst; s_sout = n_sout;
        frame(8, 20'h10); idle(39);
        frame(8, 20'h20); idle(39);
        chk("start_rst_len", 32'(n_rst - s_rst), 32'd4);
        chk("start_dropped", 32'(n_sout - s_sout), 32'd0);
        chk("start_busy",    32'(cfg_busy), 32'd0);
        strobe_in = 1'b1; stream_in = 20'h30;
        chk("lat_before", 32'(strobe_out), 32'd0);
        tick();
        chk("lat_strobe", 32'(strobe_out), 32'd1);
        chk("lat_data",   32'(stream_out), 32'h30);
        frame_part(7, 20'h31);
        strobe_in = 1'b0;
        tick();
        chk("f3_fcnt",   32'(frame_cnt), 32'd1);
        chk("f3_last",   32'(stream_out), 32'h37);
        chk("f3_beats",  32'(n_sout - s_sout), 32'd8);
        idle(39);

        // Mid-frame retune: frame forwarded whole, applied at its end
        s_sout = n_sout;
        frame_part(4, 20'h100);
        cfg_wr = 1'b1; cfg_ftw = 32'h12345678; cfg_decim = 13'd64;
        frame_part(1, 20'h104);
        cfg_wr = 1'b0;
        chk("pend_busy",  32'(cfg_busy), 32'd1);
        chk("pend_noapp", dds_ftw, 32'h0);
        frame_part(3, 20'h105);
        strobe_in = 1'b0;
        tick();
        chk("app_ftw",    dds_ftw, 32'h12345678);
        chk("app_decim",  32'(decimation), 32'd64);
        chk("app_dsprst", 32'(dsp_reset), 32'd1);
        chk("app_beats",  32'(n_sout - s_sout), 32'd8);
        chk("app_last",   32'(stream_out), 32'h107);
        chk("app_fcnt",   32'(frame_cnt), 32'd2);
        s_rst = n_rst; s_sout = n_sout;
        idle(39);
        frame(8, 20'h120); idle(39);
        frame(8, 20'h130); idle(39);
        chk("rt_rst_len", 32'(n_rst - s_rst), 32'd4);
        chk("rt_dropped", 32'(n_sout - s_sout), 32'd0);
        frame(8, 20'h140);
        chk("rt_fcnt", 32'(frame_cnt), 32'd3);
        chk("rt_busy", 32'(cfg_busy), 32'd0);
        idle(39);

        // Rejected decimation and the sticky error flag
        write_cfg(32'h99, 13'd15);
        chk("rej_err",    32'(err_decim), 32'd1);
        chk("rej_busy",   32'(cfg_busy), 32'd0);
        chk("rej_dsprst", 32'(dsp_reset), 32'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr_err", 32'(err_decim), 32'd0);
        err_clr = 1'b1; write_cfg(32'h77, 13'd8); err_clr = 1'b0;
        chk("clr_rej_err", 32'(err_decim), 32'd1);
        chk("rej_ftw",     dds_ftw, 32'h12345678);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("clr2_err", 32'(err_decim), 32'd0);

        // Minimum decimation accepted; two writes in SETTLE, last one wins
        write_cfg(32'hC0DE0001, 13'd16);
        chk("min_busy", 32'(cfg_busy), 32'd1);
        frame(8, 20'h200);
        chk("min_ftw",   dds_ftw, 32'hC0DE0001);
        chk("min_decim", 32'(decimation), 32'd16);
        chk("min_fcnt",  32'(frame_cnt), 32'd4);
        s_rst = n_rst;
        idle(10);
        chk("settle_dsprst", 32'(dsp_reset), 32'd0);
        chk("settle_busy",   32'(cfg_busy), 32'd1);
        write_cfg(32'hAAAA0000, 13'd100);
        write_cfg(32'hBBBB0000, 13'd200);
        idle(28);
        s_sout = n_sout;
        frame(8, 20'h210); idle(39);
        frame(8, 20'h220); idle(39);
        chk("ab_dropped", 32'(n_sout - s_sout), 32'd0);
        chk("ab_noapp",   dds_ftw, 32'hC0DE0001);
        chk("ab_busy",    32'(cfg_busy), 32'd1);
        frame(8, 20'h230);
        chk("ab_ftw",   dds_ftw, 32'hBBBB0000);
        chk("ab_decim", 32'(decimation), 32'd200);
        chk("ab_fcnt",  32'(frame_cnt), 32'd5);
        chk("ab_last",  32'(stream_out), 32'h237);
        idle(39);
        frame(8, 20'h240); idle(39);
        frame(8, 20'h250); idle(39);
        frame(8, 20'h260);
        chk("ab_fcnt2",  32'(frame_cnt), 32'd6);
        chk("ab_busy2",  32'(cfg_busy), 32'd0);
        chk("ab_holds",  32'(n_rst - s_rst), 32'd8);
        idle(5);

        // Frame counter wrap
        force dut.r_frame_cnt = 16'hFFFE;
        #1;
        release dut.r_frame_cnt;
        frame(8, 20'h300);
        chk("wrap_ffff", 32'(frame_cnt), 32'hFFFF);
        idle(3);
        frame(8, 20'h310);
        chk("wrap_zero", 32'(frame_cnt), 32'h0);
        chk("wrap_last", 32'(stream_out), 32'h317);
        idle(5);

        // Reset mid-PEND, with a coincident write that must be dropped
        write_cfg(32'hDEAD0000, 13'd99);
        frame_part(4, 20'h320);
        strobe_in = 1'b0; reset = 1'b1;
        cfg_wr = 1'b1; cfg_ftw = 32'h55555555; cfg_decim = 13'd32;
        tick();
        reset = 1'b0; cfg_wr = 1'b0;
        chk("mr_ftw",    dds_ftw, 32'h0);
        chk("mr_decim",  32'(decimation), 32'd48);
        chk("mr_dsprst", 32'(dsp_reset), 32'd1);
        chk("mr_sout",   32'(strobe_out), 32'd0);
        chk("mr_fcnt",   32'(frame_cnt), 32'd0);
        chk("mr_stream", 32'(stream_out), 32'd0);
        idle(43);
        frame(8, 20'h400); idle(39);
        frame(8, 20'h410); idle(39);
        frame(8, 20'h420);
        chk("mr_run_busy", 32'(cfg_busy), 32'd0);
        chk("mr_run_ftw",  dds_ftw, 32'h0);
        chk("mr_run_fcnt", 32'(frame_cnt), 32'd1);
        idle(5);

        // PEND with no frame ends: watchdog apply or indefinite wait
        write_cfg(32'h0F0F0F0F, 13'd20);
        idle(16383);
        chk("wd_early_ftw",  dds_ftw, 32'h0);
        chk("wd_early_busy", 32'(cfg_busy), 32'd1);
        tick();
`ifdef DSP_SEQ_TIMEOUT_EN
        chk("wd_ftw",    dds_ftw, 32'h0F0F0F0F);
        chk("wd_dsprst", 32'(dsp_reset), 32'd1);
`else
        chk("wd_ftw",    dds_ftw, 32'h0);
        chk("wd_dsprst", 32'(dsp_reset), 32'd0);
        chk("wd_busy",   32'(cfg_busy), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
